// File: rtl/fifo_arb_pkg.sv
// Shared constants, FSM encoding and destination decode for the upstream-to-downstream FIFO arbiter.
package fifo_arb_pkg;

  localparam int unsigned NUM_PORTS  = 4;
  localparam int unsigned DATA_WIDTH = 6;
  localparam int unsigned DEST_MSB   = 5;
  localparam int unsigned DEST_LSB   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_PAUSE  = 2'b10
  } arb_state_e;

  function automatic logic [NUM_PORTS-1:0] dest_onehot(input logic [DEST_MSB-DEST_LSB:0] dest);
    logic [NUM_PORTS-1:0] oh;
    oh       = '0;
    oh[dest] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_grant4.sv
// Combinational 4-way round-robin grant: search starts one past last_grant and wraps.
module rr_grant4 (
  input  logic [3:0] request,
  input  logic [1:0] last_grant,
  output logic [3:0] grant
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Pops non-empty upstream FIFOs one word per cycle and routes each word by its destination field.
// Define FIFO_ARB_STRICT_PRIORITY_EN for fixed priority (port 0 highest) instead of round-robin.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            fifo_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_PORTS-1:0]            fifo_pop,
  input  logic [NUM_PORTS-1:0]            down_almost_full,
  output logic [NUM_PORTS-1:0]            down_push,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic [1:0]                      arb_state
);

  arb_state_e              state_q, state_d;
  logic [NUM_PORTS-1:0]    pop_q, request, grant;
  logic [NUM_PORTS-1:0]    down_push_q, down_push_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d, popped_word;
  logic                    pop_allow, any_ready, any_af;

  assign any_ready = ~&fifo_empty;
  assign any_af    = |down_almost_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_ready && !any_af) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (any_af)          state_d = ST_PAUSE;
        else if (!any_ready) state_d = ST_IDLE;
      end
      ST_PAUSE:  if (!any_af) state_d = any_ready ? ST_ACTIVE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A port popped last cycle sits out one cycle so its empty flag can catch up.
  always_comb begin
    pop_allow = reset && (state_q != ST_PAUSE) && !any_af;
    request   = pop_allow ? (~fifo_empty & ~pop_q) : '0;
    fifo_pop  = grant;
    down_push = down_push_q;
    data_out  = data_out_q;
    arb_state = state_q;
  end

`ifdef FIFO_ARB_STRICT_PRIORITY_EN
  // Isolate the lowest set request bit.
  assign grant = request & (~request + NUM_PORTS'(1));
`else
  logic [1:0] last_grant_q, last_grant_d;

  rr_grant4 u_rr_grant4 (
    .request    (request),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) last_grant_d = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= 2'd3;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // The word popped last cycle is on its slice now; the other slices may carry garbage.
  always_comb begin
    popped_word = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pop_q[i]) popped_word = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    down_push_d = '0;
    data_out_d  = data_out_q;
    if (|pop_q) begin
      down_push_d = dest_onehot(popped_word[DEST_MSB:DEST_LSB]);
      data_out_d  = popped_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_q       <= '0;
      down_push_q <= '0;
      data_out_q  <= '0;
    end else begin
      pop_q       <= fifo_pop;
      down_push_q <= down_push_d;
      data_out_q  <= data_out_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: directed scenarios plus random traffic against a
// queue-based reference of the upstream FIFOs, grant rules and 2-cycle push pipeline.
module tb_fifo_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  fifo_empty, fifo_pop, down_almost_full, down_push;
  logic [23:0] fifo_data;
  logic [5:0]  data_out;
  logic [1:0]  arb_state;

  always #5 clk = ~clk;

  fifo_rr_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_empty       (fifo_empty),
    .fifo_data        (fifo_data),
    .fifo_pop         (fifo_pop),
    .down_almost_full (down_almost_full),
    .down_push        (down_push),
    .data_out         (data_out),
    .arb_state        (arb_state)
  );

  int errors = 0;
  int checks = 0;

  logic [5:0] upq [4][$];
  int         m_state, m_lg, m_prev, m_cyc;
  int         due_q[$];
  logic [5:0] word_q[$];
  logic [5:0] m_data, held_word;
  int         held_port;
  logic       rst_drv;
  logic [3:0] af_drv;

  logic [3:0] exp_pop, exp_push, act_pop, act_push;
  logic [5:0] exp_data, act_data;
  logic [1:0] exp_state, act_state;

  // One clock cycle: drive inputs, sample DUT, compute reference outputs, advance the reference.
  task automatic cycle();
    int         g;
    bit         any_ready;
    logic [5:0] w;
    @(negedge clk);
    reset            = rst_drv;
    down_almost_full = af_drv;
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]      = (upq[i].size() == 0);
      fifo_data[i*6 +: 6] = (held_port == i) ? held_word : 6'($urandom);
    end
    #1;
    act_pop   = fifo_pop;
    act_push  = down_push;
    act_data  = data_out;
    act_state = arb_state;

    any_ready = 1'b0;
    for (int i = 0; i < 4; i++) if (upq[i].size() > 0) any_ready = 1'b1;
    g = -1;
    if (rst_drv && m_state != 2 && af_drv == 4'd0) begin
`ifdef FIFO_ARB_STRICT_PRIORITY_EN
      for (int k = 0; k < 4; k++)
        if (g < 0 && upq[k].size() > 0 && k != m_prev) g = k;
`else
      for (int k = 1; k <= 4; k++) begin
        int p;
        p = (m_lg + k) % 4;
        if (g < 0 && upq[p].size() > 0 && p != m_prev) g = p;
      end
`endif
    end
    exp_pop   = (g < 0) ? 4'd0 : 4'(1 << g);
    exp_push  = 4'd0;
    exp_data  = m_data;
    exp_state = 2'(m_state);
    if (due_q.size() > 0 && due_q[0] == m_cyc) begin
      void'(due_q.pop_front());
      w        = word_q.pop_front();
      exp_push = 4'(1 << w[5:4]);
      exp_data = w;
      m_data   = w;
    end

    held_port = -1;
    if (!rst_drv) begin
      m_state = 0; m_lg = 3; m_prev = -1; m_data = 6'd0;
      due_q.delete(); word_q.delete();
    end else begin
      if (g >= 0) begin
        held_word = upq[g].pop_front();
        held_port = g;
        due_q.push_back(m_cyc + 2);
        word_q.push_back(held_word);
        m_lg = g;
      end
      m_prev = g;
      if (m_state == 0) begin
        if (any_ready && af_drv == 4'd0) m_state = 1;
      end else if (m_state == 1) begin
        if (af_drv != 4'd0) m_state = 2;
        else if (!any_ready) m_state = 0;
      end else begin
        if (af_drv == 4'd0) m_state = any_ready ? 1 : 0;
      end
    end
    m_cyc++;
  endtask

  task automatic start();
    for (int i = 0; i < 4; i++) upq[i].delete();
    af_drv  = 4'd0;
    rst_drv = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    start();
    for (int i = 0; i < 4; i++) repeat (2) upq[i].push_back(6'($urandom));
    repeat (3) begin
      cycle();
      checks++;
      if (act_pop !== 4'd0 || act_push !== 4'd0 || act_data !== 6'd0 || act_state !== 2'b00) begin
        errors++;
        $display("FAIL reset_outputs pop=%b push=%b data=%h state=%b, want all zero",
                 act_pop, act_push, act_data, act_state);
      end
    end
    rst_drv = 1'b1;
    cycle();
    checks++;
    if (act_pop !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_pop got %b want 0001", act_pop);
    end
  endtask

  task automatic test_pipeline();
    logic [5:0] w2;
    start();
    w2 = 6'($urandom);
    upq[0].push_back(6'b10_0101);
    upq[2].push_back(w2);
    rst_drv = 1'b1;
    cycle();
    checks++;
    if (act_pop !== 4'b0001) begin errors++; $display("FAIL pipe_pop0 got %b want 0001", act_pop); end
    cycle();
    checks++;
    if (act_pop !== 4'b0100) begin errors++; $display("FAIL pipe_pop2 got %b want 0100", act_pop); end
    cycle();
    checks++;
    if (act_push !== 4'b0100 || act_data !== 6'h25) begin
      errors++;
      $display("FAIL pipe_push0 push=%b data=%h want 0100/25", act_push, act_data);
    end
    cycle();
    checks++;
    if (act_push !== 4'(1 << w2[5:4]) || act_data !== w2) begin
      errors++;
      $display("FAIL pipe_push2 push=%b data=%h want %b/%h", act_push, act_data,
               4'(1 << w2[5:4]), w2);
    end
  endtask

  task automatic test_single_port();
    logic [5:0] w [3];
    start();
    for (int i = 0; i < 3; i++) begin w[i] = 6'($urandom); upq[1].push_back(w[i]); end
    rst_drv = 1'b1;
    for (int n = 0; n < 8; n++) begin
      logic [3:0] want_pop, want_push;
      cycle();
      want_pop  = (n == 0 || n == 2 || n == 4) ? 4'b0010 : 4'd0;
      want_push = (n == 2 || n == 4 || n == 6) ? 4'(1 << w[n/2-1][5:4]) : 4'd0;
      checks++;
      if (act_pop !== want_pop) begin
        errors++;
        $display("FAIL single_pop n=%0d got %b want %b", n, act_pop, want_pop);
      end
      checks++;
      if (act_push !== want_push) begin
        errors++;
        $display("FAIL single_push n=%0d got %b want %b", n, act_push, want_push);
      end
    end
  endtask

  task automatic test_round_robin();
    int seq [5];
`ifdef FIFO_ARB_STRICT_PRIORITY_EN
    seq = '{0, 1, 0, 1, 2};
`else
    seq = '{0, 1, 2, 3, 0};
`endif
    start();
    for (int i = 0; i < 4; i++) repeat (2) upq[i].push_back(6'($urandom));
    rst_drv = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cycle();
      checks++;
      if (act_pop !== 4'(1 << seq[n])) begin
        errors++;
        $display("FAIL order n=%0d got %b want %b", n, act_pop, 4'(1 << seq[n]));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] wa, wb;
    start();
    wa = 6'($urandom);
    wb = 6'($urandom);
    upq[0].push_back(wa);
    upq[1].push_back(wb);
    for (int i = 0; i < 4; i++) repeat (3) upq[i].push_back(6'($urandom));
    rst_drv = 1'b1;
    cycle();
    cycle();
    af_drv = 4'b1000;
    cycle();
    checks++;
    if (act_pop !== 4'd0 || act_push !== 4'(1 << wa[5:4]) || act_data !== wa) begin
      errors++;
      $display("FAIL bp_first pop=%b push=%b data=%h want 0000/%b/%h", act_pop, act_push,
               act_data, 4'(1 << wa[5:4]), wa);
    end
    cycle();
    checks++;
    if (act_pop !== 4'd0 || act_push !== 4'(1 << wb[5:4]) || act_state !== 2'b10) begin
      errors++;
      $display("FAIL bp_second pop=%b push=%b state=%b want 0000/%b/10", act_pop, act_push,
               act_state, 4'(1 << wb[5:4]));
    end
    cycle();
    checks++;
    if (act_pop !== 4'd0 || act_push !== 4'd0) begin
      errors++;
      $display("FAIL bp_hold pop=%b push=%b want 0000/0000", act_pop, act_push);
    end
    af_drv = 4'd0;
    cycle();
    checks++;
    if (act_pop !== 4'd0 || act_state !== 2'b10) begin
      errors++;
      $display("FAIL bp_clear pop=%b state=%b want 0000/10", act_pop, act_state);
    end
    cycle();
    checks++;
`ifdef FIFO_ARB_STRICT_PRIORITY_EN
    if (act_pop !== 4'b0001 || act_state !== 2'b01) begin
      errors++;
      $display("FAIL bp_resume pop=%b state=%b want 0001/01", act_pop, act_state);
    end
`else
    if (act_pop !== 4'b0100 || act_state !== 2'b01) begin
      errors++;
      $display("FAIL bp_resume pop=%b state=%b want 0100/01", act_pop, act_state);
    end
`endif
  endtask

  task automatic test_reset_mid();
    start();
    upq[2].push_back(6'b11_1010);
    rst_drv = 1'b1;
    cycle();
    checks++;
    if (act_pop !== 4'b0100) begin errors++; $display("FAIL mid_pop got %b want 0100", act_pop); end
    rst_drv = 1'b0;
    cycle();
    for (int i = 0; i < 4; i++) upq[i].delete();
    rst_drv = 1'b1;
    repeat (4) begin
      cycle();
      checks++;
      if (act_pop !== 4'd0 || act_push !== 4'd0 || act_data !== 6'd0 || act_state !== 2'b00) begin
        errors++;
        $display("FAIL mid_reset pop=%b push=%b data=%h state=%b, want all zero",
                 act_pop, act_push, act_data, act_state);
      end
    end
  endtask

  task automatic test_random();
    int af_hold = 0;
    start();
    rst_drv = 1'b1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        if (upq[i].size() < 4 && $urandom_range(3) == 0) upq[i].push_back(6'($urandom));
      if (af_hold > 0) af_hold--;
      else if ($urandom_range(9) == 0) begin af_drv = 4'($urandom_range(15, 1)); af_hold = 3; end
      else af_drv = 4'd0;
      rst_drv = ($urandom_range(79) != 0);
      cycle();
      checks++;
      if (act_pop !== exp_pop) begin
        errors++; $display("FAIL rand_pop n=%0d got %b want %b", n, act_pop, exp_pop);
      end
      checks++;
      if (act_push !== exp_push) begin
        errors++; $display("FAIL rand_push n=%0d got %b want %b", n, act_push, exp_push);
      end
      checks++;
      if (act_data !== exp_data) begin
        errors++; $display("FAIL rand_data n=%0d got %h want %h", n, act_data, exp_data);
      end
      checks++;
      if (act_state !== exp_state) begin
        errors++; $display("FAIL rand_state n=%0d got %b want %b", n, act_state, exp_state);
      end
    end
  endtask

  initial begin
    reset            = 1'b0;
    fifo_empty       = 4'hf;
    fifo_data        = '0;
    down_almost_full = 4'd0;
    rst_drv          = 1'b0;
    af_drv           = 4'd0;
    held_port        = -1;
    held_word        = 6'd0;
    m_state = 0; m_lg = 3; m_prev = -1; m_cyc = 0; m_data = 6'd0;
    cycle();
    test_reset();
    test_pipeline();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
